// File: rtl/gf2_mul_pkg.sv
// rtl/gf2_mul_pkg.sv - shared state encoding and width helpers for the GF(2) limb datapath
package gf2_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  function automatic int shift_w(input int k);
    int w;
    w = $clog2(2 * k - 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int acc_w(input int n, input int k);
    return 2 * k * n;
  endfunction

  function automatic int cnt_w(input int k);
    return $clog2(k * k + 1);
  endfunction

endpackage

// File: rtl/gf2_shift_xor.sv
// rtl/gf2_shift_xor.sv - XORs a 2N-coefficient limb product into the accumulator at offset shift*N
module gf2_shift_xor
  import gf2_mul_pkg::*;
#(
  parameter int N = 256,
  parameter int K = 4,
  localparam int SHIFT_W = shift_w(K),
  localparam int ACC_W = acc_w(N, K)
) (
  input  logic [0:ACC_W-1]   acc_in,
  input  logic [0:2*N-1]     prod,
  input  logic [SHIFT_W-1:0] shift,
  output logic [0:ACC_W-1]   acc_out
);

  // Shifts above 2K-2 leave the accumulator untouched; the window never wraps.
  always_comb begin
    acc_out = acc_in;
    for (int s = 0; s <= 2 * K - 2; s++) begin
      if (shift == SHIFT_W'(s)) begin
        acc_out[s*N +: 2*N] = acc_in[s*N +: 2*N] ^ prod;
      end
    end
  end

endmodule

// File: rtl/gf2_overlap_accumulator.sv
// rtl/gf2_overlap_accumulator.sv - XOR-accumulates limb products into the full GF(2) polynomial product
// Optional beat-count checking is enabled by GF2_OVERLAP_BEAT_CHECK_EN.
module gf2_overlap_accumulator
  import gf2_mul_pkg::*;
#(
  parameter int N = 256,
  parameter int K = 4,
  localparam int SHIFT_W = shift_w(K),
  localparam int ACC_W = acc_w(N, K)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:2*N-1]     in_prod,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:ACC_W-1]   out_poly,
  output logic               err
);

  localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(2 * K - 2);

  state_e             state_q, state_d;
  logic [0:ACC_W-1]   acc_q, acc_d, acc_xor;
  logic               err_q, err_d;
  logic               beat_acc;
  logic               shift_ok;

`ifdef GF2_OVERLAP_BEAT_CHECK_EN
  localparam int CNT_W = cnt_w(K);
  localparam logic [CNT_W-1:0] BEATS = CNT_W'(K * K);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  gf2_shift_xor #(.N(N), .K(K)) u_shift_xor (
    .acc_in  (acc_q),
    .prod    (in_prod),
    .shift   (in_shift),
    .acc_out (acc_xor)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_poly  = acc_q;
  assign err       = err_q;
  // start wins over a same-cycle beat, so that beat is dropped.
  assign beat_acc  = in_valid && in_ready && !start;
  assign shift_ok  = (in_shift <= MAX_SHIFT);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
`ifdef GF2_OVERLAP_BEAT_CHECK_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          err_d   = 1'b0;
`ifdef GF2_OVERLAP_BEAT_CHECK_EN
          cnt_d   = '0;
`endif
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (start) begin
          acc_d = '0;
          err_d = 1'b0;
`ifdef GF2_OVERLAP_BEAT_CHECK_EN
          cnt_d = '0;
`endif
        end else if (beat_acc) begin
          if (shift_ok) acc_d = acc_xor;
          else          err_d = 1'b1;
`ifdef GF2_OVERLAP_BEAT_CHECK_EN
          if (in_last && (cnt_q != BEATS - 1'b1)) err_d = 1'b1;
          if (!in_last && (cnt_q == BEATS))       err_d = 1'b1;
          if (cnt_q != BEATS)                     cnt_d = cnt_q + 1'b1;
`endif
          if (in_last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      err_q   <= 1'b0;
`ifdef GF2_OVERLAP_BEAT_CHECK_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
`ifdef GF2_OVERLAP_BEAT_CHECK_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_gf2_overlap_accumulator.sv
// tb/tb_gf2_overlap_accumulator.sv - scoreboard bench for gf2_overlap_accumulator at N=4, K=2
module tb_gf2_overlap_accumulator;

  localparam int N  = 4;
  localparam int K  = 2;
  localparam int SW = 2;
  localparam int AW = 16;

  typedef struct {
    logic [0:AW-1] poly;
    logic          err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            out_ready = 1'b0;
  logic [0:2*N-1]  in_prod = '0;
  logic [SW-1:0]   in_shift = '0;
  logic            in_ready;
  logic            out_valid;
  logic            err;
  logic [0:AW-1]   out_poly;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  int beat_s[$];
  logic [0:2*N-1] beat_p[$];

  gf2_overlap_accumulator #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_shift  (in_shift),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_poly  (out_poly),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: every legal beat flips coefficient s*N+j for each set bit j of its product.
  function automatic exp_t model();
    exp_t e;
    e.poly = '0;
    e.err  = 1'b0;
    for (int b = 0; b < beat_s.size(); b++) begin
      if (beat_s[b] > 2 * K - 2) e.err = 1'b1;
      else
        for (int j = 0; j < 2 * N; j++)
          if (beat_p[b][j]) e.poly[beat_s[b] * N + j] = ~e.poly[beat_s[b] * N + j];
    end
`ifdef GF2_OVERLAP_BEAT_CHECK_EN
    if (beat_s.size() != K * K) e.err = 1'b1;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", out_poly);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_poly", out_poly, e.poly);
        check("err", err, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic add_beat(input int s, input logic [0:2*N-1] p);
    beat_s.push_back(s);
    beat_p.push_back(p);
  endtask

  task automatic clear_beats();
    beat_s.delete();
    beat_p.delete();
  endtask

  task automatic send_beats(input bit gaps);
    exp_q.push_back(model());
    for (int b = 0; b < beat_s.size(); b++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_shift = SW'(beat_s[b]);
      in_prod  = beat_p[b];
      in_last  = (b == beat_s.size() - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input int stall);
    bit done;
    done = 1'b0;
    out_ready = 1'b0;
    repeat (stall) tick();
    out_ready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (out_valid) done = 1'b1;
      tick();
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=no_out_valid required=out_valid");
    end
  endtask

  task automatic run_job(input int stall, input bit gaps);
    do_start();
    send_beats(gaps);
    drain(stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [0:2*N-1] p;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_poly", out_poly, 0);
    check("reset_err", err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    clear_beats();
    add_beat(0, 8'b10000000);
    run_job(0, 1'b0);

    clear_beats();
    add_beat(0, 8'b11110000);
    add_beat(1, 8'b11110000);
    add_beat(2, 8'b00010000);
    run_job(1, 1'b0);

    clear_beats();
    add_beat(1, 8'b10100000);
    add_beat(1, 8'b10100000);
    run_job(0, 1'b0);

    clear_beats();
    add_beat(3, 8'b11111111);
    add_beat(0, 8'b01000000);
    run_job(2, 1'b0);

    // Result must hold in DONE while start and in_valid are wiggled.
    clear_beats();
    add_beat(1, 8'b01100000);
    add_beat(2, 8'b00110010);
    e = model();
    out_ready = 1'b0;
    do_start();
    send_beats(1'b0);
    for (int i = 0; i < 5; i++) begin
      start    = (i == 1);
      in_valid = (i == 2 || i == 3);
      in_prod  = 8'b11111110;
      in_shift = SW'(0);
      @(negedge clk);
      check("done_hold_poly", out_poly, e.poly);
      check("done_in_ready", in_ready, 0);
      check("done_out_valid", out_valid, 1);
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 0);
    tick();

    // Abort: illegal beat sets err, then start with a same-cycle beat that must be dropped.
    do_start();
    in_valid = 1'b1;
    in_shift = SW'(3);
    in_prod  = 8'b10101010;
    tick();
    start = 1'b1;
    in_shift = SW'(0);
    in_prod  = 8'b11100000;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_err_cleared", err, 0);
    check("abort_acc_cleared", out_poly, 0);
    check("abort_in_ready", in_ready, 1);
    tick();
    clear_beats();
    add_beat(2, 8'b00011000);
    add_beat(1, 8'b10000100);
    add_beat(0, 8'b01010000);
    add_beat(2, 8'b00000010);
    send_beats(1'b0);
    drain(0);

    // Asynchronous reset mid-job.
    do_start();
    in_valid = 1'b1;
    in_shift = SW'(3);
    in_prod  = 8'b01000000;
    tick();
    in_shift = SW'(1);
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_poly", out_poly, 0);
    check("midreset_err", err, 0);
    check("midreset_in_ready", in_ready, 0);
    check("midreset_out_valid", out_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int j = 0; j < 30; j++) begin
      int nb;
      clear_beats();
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        p = 8'($urandom);
        p[2*N-1] = 1'b0;
        add_beat(($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2), p);
      end
      run_job($urandom_range(0, 3), 1'b1);
    end

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
